// File: rtl/code_frame_receiver.sv
// code_frame_receiver
//
// Serial frame receiver between the FSK bit slicer and the Hamming decoder.
// A frame is a start bit (1), DATA_W payload bits, an optional even-parity
// bit and an optional stop bit (0). The line idles at 0. Bits are taken only
// on cycles where io_bit_en is high. Good words go to a one-entry valid/ready
// holding register.
//
// Parameters:
//   DATA_W    payload width, 2..32
//   MSB_FIRST 1: first payload bit lands in bit DATA_W-1; 0: in bit 0
//   PARITY_EN 1: an even-parity bit follows the payload
//   STOP_EN   1: a stop bit (expected 0) follows the payload/parity
//
// Ports:
//   clock, reset   system clock, synchronous active-high reset
//   io_input       serial bit from the slicer
//   io_bit_en      bit strobe; io_input is sampled only when high
//   io_out_data    word in the holding register
//   io_out_valid   holding register holds an unconsumed word
//   io_out_ready   consumer takes the word when valid && ready
//   io_last_word   most recent good word
//   io_busy        receiver is inside a frame
//   io_frame_err   one-cycle pulse: stop bit sampled as 1
//   io_parity_err  one-cycle pulse: parity mismatch
//   io_overrun     one-cycle pulse: good word dropped, holding register full
//
// States:
//   S_IDLE   | waiting for a start bit
//   S_DATA   | shifting in payload bits
//   S_PARITY | sampling the parity bit
//   S_STOP   | sampling the stop bit

module code_frame_receiver #(
    parameter int DATA_W    = 8,
    parameter int MSB_FIRST = 1,
    parameter int PARITY_EN = 0,
    parameter int STOP_EN   = 1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              io_input,
    input  logic              io_bit_en,
    output logic [DATA_W-1:0] io_out_data,
    output logic              io_out_valid,
    input  logic              io_out_ready,
    output logic [DATA_W-1:0] io_last_word,
    output logic              io_busy,
    output logic              io_frame_err,
    output logic              io_parity_err,
    output logic              io_overrun
);

    localparam int CNT_W = $clog2(DATA_W);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    state_t            state, state_n;
    logic [CNT_W-1:0]  cnt, cnt_n;
    logic [DATA_W-1:0] shift, shift_n, shifted;
    logic              parity_bad, parity_bad_n;

    logic [DATA_W-1:0] out_data_n, last_word_n;
    logic              out_valid_n;
    logic              frame_err_n, parity_err_n, overrun_n;

    logic              frame_end;
    logic [DATA_W-1:0] word;
    logic              err_frame, err_parity;
    logic              consume;

    always_ff @(posedge clock) begin
        if (reset) begin
            state         <= S_IDLE;
            cnt           <= '0;
            shift         <= '0;
            parity_bad    <= 1'b0;
            io_out_data   <= '0;
            io_out_valid  <= 1'b0;
            io_last_word  <= '0;
            io_frame_err  <= 1'b0;
            io_parity_err <= 1'b0;
            io_overrun    <= 1'b0;
        end else begin
            state         <= state_n;
            cnt           <= cnt_n;
            shift         <= shift_n;
            parity_bad    <= parity_bad_n;
            io_out_data   <= out_data_n;
            io_out_valid  <= out_valid_n;
            io_last_word  <= last_word_n;
            io_frame_err  <= frame_err_n;
            io_parity_err <= parity_err_n;
            io_overrun    <= overrun_n;
        end
    end

    // Shift direction decides where the first payload bit ends up.
    always_comb begin
        if (MSB_FIRST != 0) shifted = {shift[DATA_W-2:0], io_input};
        else                shifted = {io_input, shift[DATA_W-1:1]};
    end

    // Frame sequencing: advances only on strobe cycles.
    always_comb begin
        state_n      = state;
        cnt_n        = cnt;
        shift_n      = shift;
        parity_bad_n = parity_bad;
        frame_end    = 1'b0;
        word         = shift;
        err_frame    = 1'b0;
        err_parity   = 1'b0;

        if (io_bit_en) begin
            case (state)
                S_IDLE: begin
                    if (io_input) begin
                        state_n      = S_DATA;
                        cnt_n        = '0;
                        shift_n      = '0;
                        parity_bad_n = 1'b0;
                    end
                end
                S_DATA: begin
                    shift_n = shifted;
                    if (cnt == LAST_BIT) begin
                        cnt_n = '0;
                        if (PARITY_EN != 0) begin
                            state_n = S_PARITY;
                        end else if (STOP_EN != 0) begin
                            state_n = S_STOP;
                        end else begin
                            state_n   = S_IDLE;
                            frame_end = 1'b1;
                            word      = shifted;
                        end
                    end else begin
                        cnt_n = cnt + 1'b1;
                    end
                end
                S_PARITY: begin
                    // Even parity: payload XOR parity bit must be 0.
                    parity_bad_n = (^shift) ^ io_input;
                    if (STOP_EN != 0) begin
                        state_n = S_STOP;
                    end else begin
                        state_n    = S_IDLE;
                        frame_end  = 1'b1;
                        err_parity = (^shift) ^ io_input;
                    end
                end
                S_STOP: begin
                    // A stop bit of 1 is an error, never a new start bit.
                    state_n    = S_IDLE;
                    frame_end  = 1'b1;
                    err_frame  = io_input;
                    err_parity = parity_bad;
                end
                default: state_n = S_IDLE;
            endcase
        end
    end

    // Holding register and status pulses: evaluated every cycle.
    always_comb begin
        consume      = io_out_valid && io_out_ready;
        out_data_n   = io_out_data;
        out_valid_n  = io_out_valid && !io_out_ready;
        last_word_n  = io_last_word;
        overrun_n    = 1'b0;
        frame_err_n  = frame_end && err_frame;
        parity_err_n = frame_end && err_parity;

        if (frame_end && !err_frame && !err_parity) begin
            last_word_n = word;
            // A word being consumed this cycle frees the slot for the new one.
            if (!io_out_valid || consume) begin
                out_data_n  = word;
                out_valid_n = 1'b1;
            end else begin
                overrun_n = 1'b1;
            end
        end
    end

    assign io_busy = (state != S_IDLE);

endmodule

// File: tb/tb_code_frame_receiver.sv
// Directed bench for code_frame_receiver. Three instances share the input
// stimulus: defaults (MSB first, stop bit), LSB first, and parity enabled.
// Each scenario begins with a reset so instances not under test start clean.

module tb_code_frame_receiver;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       io_input = 1'b0;
    logic       io_bit_en = 1'b0;
    logic       io_out_ready = 1'b0;

    logic [7:0] d_data, d_last;
    logic       d_valid, d_busy, d_ferr, d_perr, d_ovr;
    logic [7:0] l_data, l_last;
    logic       l_valid, l_busy, l_ferr, l_perr, l_ovr;
    logic [7:0] p_data, p_last;
    logic       p_valid, p_busy, p_ferr, p_perr, p_ovr;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clock = ~clock;

    code_frame_receiver u_dut (
        .clock(clock), .reset(reset), .io_input(io_input), .io_bit_en(io_bit_en),
        .io_out_data(d_data), .io_out_valid(d_valid), .io_out_ready(io_out_ready),
        .io_last_word(d_last), .io_busy(d_busy), .io_frame_err(d_ferr),
        .io_parity_err(d_perr), .io_overrun(d_ovr)
    );

    code_frame_receiver #(.MSB_FIRST(0)) u_lsb (
        .clock(clock), .reset(reset), .io_input(io_input), .io_bit_en(io_bit_en),
        .io_out_data(l_data), .io_out_valid(l_valid), .io_out_ready(io_out_ready),
        .io_last_word(l_last), .io_busy(l_busy), .io_frame_err(l_ferr),
        .io_parity_err(l_perr), .io_overrun(l_ovr)
    );

    code_frame_receiver #(.PARITY_EN(1)) u_par (
        .clock(clock), .reset(reset), .io_input(io_input), .io_bit_en(io_bit_en),
        .io_out_data(p_data), .io_out_valid(p_valid), .io_out_ready(io_out_ready),
        .io_last_word(p_last), .io_busy(p_busy), .io_frame_err(p_ferr),
        .io_parity_err(p_perr), .io_overrun(p_ovr)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        io_bit_en = 1'b0;
        io_input = 1'b0;
        repeat (2) @(negedge clock);
        reset = 1'b0;
    endtask

    // Sends bits[n-1] down to bits[0], one per strobe, with `gap` idle
    // cycles before each strobe. rdy_end raises ready on the last bit's cycle.
    task automatic send_seq(input logic [15:0] bits, input int n, input int gap,
                            input logic rdy_end);
        for (int i = n - 1; i >= 0; i--) begin
            io_bit_en = 1'b0;
            repeat (gap) @(negedge clock);
            io_input  = bits[i];
            io_bit_en = 1'b1;
            if (i == 0 && rdy_end) io_out_ready = 1'b1;
            @(negedge clock);
            io_bit_en = 1'b0;
            io_input  = 1'b0;
            if (i == 0 && rdy_end) io_out_ready = 1'b0;
        end
    endtask

    initial begin
        do_reset();
        check("rst_valid", d_valid, 0);
        check("rst_data", d_data, 8'h00);
        check("rst_last", d_last, 8'h00);
        check("rst_busy", d_busy, 0);
        check("rst_errs", {d_ferr, d_perr, d_ovr}, 3'b000);

        // Basic frame, strobe every cycle: 1,1,0,1,1,0,1,0,0 then stop 0.
        do_reset();
        send_seq(16'b110110100, 9, 0, 1'b0);
        check("b4_pre_stop_valid", d_valid, 0);
        check("b4_pre_stop_busy", d_busy, 1);
        send_seq(16'b0, 1, 0, 1'b0);
        check("b4_valid", d_valid, 1);
        check("b4_data", d_data, 8'hB4);
        check("b4_last", d_last, 8'hB4);
        check("b4_busy", d_busy, 0);
        check("lsb_valid", l_valid, 1);
        check("lsb_data", l_data, 8'h2D);
        // Parity instance took the 10th bit as a (good) parity bit.
        check("par_wait_valid", p_valid, 0);
        send_seq(16'b0, 1, 0, 1'b0);
        check("par_b4_valid", p_valid, 1);
        check("par_b4_data", p_data, 8'hB4);

        // Strobe every third cycle, 0x5A, with a long freeze mid-frame.
        do_reset();
        send_seq(16'b10101, 5, 2, 1'b0);
        io_bit_en = 1'b0;
        repeat (7) @(negedge clock);
        check("freeze_busy", d_busy, 1);
        check("freeze_valid", d_valid, 0);
        send_seq(16'b10100, 5, 2, 1'b0);
        check("5a_valid", d_valid, 1);
        check("5a_data", d_data, 8'h5A);

        // Parity: bad then good then bad with a different word.
        do_reset();
        send_seq({5'b0, 1'b1, 8'hB4, 1'b1, 1'b0}, 11, 0, 1'b0);
        check("perr_pulse", p_perr, 1);
        check("perr_no_ferr", p_ferr, 0);
        check("perr_valid", p_valid, 0);
        check("perr_last", p_last, 8'h00);
        @(negedge clock);
        check("perr_one_cycle", p_perr, 0);
        send_seq({5'b0, 1'b1, 8'hB4, 1'b0, 1'b0}, 11, 0, 1'b0);
        check("pgood_valid", p_valid, 1);
        check("pgood_data", p_data, 8'hB4);
        check("pgood_perr", p_perr, 0);
        send_seq({5'b0, 1'b1, 8'h3C, 1'b1, 1'b0}, 11, 0, 1'b0);
        check("perr2_pulse", p_perr, 1);
        check("perr2_last", p_last, 8'hB4);
        check("perr2_data", p_data, 8'hB4);

        // Stop bit = 1, then an immediate good frame.
        do_reset();
        send_seq({6'b0, 1'b1, 8'h77, 1'b1}, 10, 0, 1'b0);
        check("ferr_pulse", d_ferr, 1);
        check("ferr_valid", d_valid, 0);
        check("ferr_busy", d_busy, 0);
        check("ferr_last", d_last, 8'h00);
        send_seq({6'b0, 1'b1, 8'h3C, 1'b0}, 10, 0, 1'b0);
        check("after_ferr_valid", d_valid, 1);
        check("after_ferr_data", d_data, 8'h3C);
        check("after_ferr_ferr", d_ferr, 0);

        // Overrun with ready held low.
        do_reset();
        send_seq({6'b0, 1'b1, 8'h11, 1'b0}, 10, 0, 1'b0);
        check("ovr_first", d_data, 8'h11);
        send_seq({6'b0, 1'b1, 8'h22, 1'b0}, 10, 0, 1'b0);
        check("ovr_data_held", d_data, 8'h11);
        check("ovr_valid", d_valid, 1);
        check("ovr_pulse", d_ovr, 1);
        check("ovr_last", d_last, 8'h22);
        @(negedge clock);
        check("ovr_one_cycle", d_ovr, 0);

        // Consume and refill on the same edge: no overrun.
        do_reset();
        send_seq({6'b0, 1'b1, 8'h11, 1'b0}, 10, 0, 1'b0);
        send_seq({6'b0, 1'b1, 8'h22, 1'b0}, 10, 0, 1'b1);
        check("swap_data", d_data, 8'h22);
        check("swap_valid", d_valid, 1);
        check("swap_no_ovr", d_ovr, 0);
        io_out_ready = 1'b1;
        @(negedge clock);
        io_out_ready = 1'b0;
        check("drain_valid", d_valid, 0);

        // Reset in the middle of a frame.
        send_seq(16'b1011, 4, 0, 1'b0);
        check("mid_busy", d_busy, 1);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        check("mrst_busy", d_busy, 0);
        check("mrst_data", d_data, 8'h00);
        check("mrst_last", d_last, 8'h00);
        check("mrst_valid", d_valid, 0);
        send_seq({6'b0, 1'b1, 8'h96, 1'b0}, 10, 0, 1'b0);
        check("mrst_next_valid", d_valid, 1);
        check("mrst_next_data", d_data, 8'h96);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/code_frame_receiver.md
Name: code_frame_receiver

Overview:
Parametrised serial frame receiver for the FSK/Hamming datapath. It sits after the demodulator's bit slicer and before the Hamming decoder. It detects a start bit and shifts in DATA_W payload bits, most- or least-significant bit first. It optionally checks an even-parity bit and a stop bit, then delivers each word through a one-entry valid/ready holding register. Bits are sampled only on cycles where the bit strobe is high, so one bit per clock is no longer hard-wired.

Parameters:
DATA_W, 8, payload width in bits; legal range 2..32.
MSB_FIRST, 1, 1 = first received payload bit lands in bit DATA_W-1; 0 = first bit lands in bit 0.
PARITY_EN, 0, 1 = one even-parity bit follows the payload.
STOP_EN, 1, 1 = one stop bit (value 0) follows the payload/parity.

Ports:
clock  in  1  system clock
reset  in  1  synchronous, active-high reset
io_input  in  1  serial bit from slicer; line idles at 0; start bit = 1
io_bit_en  in  1  bit strobe; io_input is sampled only when this is 1
io_out_data  out  DATA_W  received word in the holding register
io_out_valid  out  1  holding register contains an unconsumed word
io_out_ready  in  1  consumer accepts the word when valid && ready
io_last_word  out  DATA_W  most recent good word, held until the next good word
io_busy  out  1  1 in any state other than IDLE
io_frame_err  out  1  one-cycle pulse: stop bit sampled as 1
io_parity_err  out  1  one-cycle pulse: parity mismatch
io_overrun  out  1  one-cycle pulse: good word dropped because the holding register was full

Behaviour:
- Reset (synchronous, active-high; clock clock):
  - State = IDLE; bit counter = 0; shift register = 0.
  - io_out_data = 0, io_out_valid = 0, io_last_word = 0.
  - All error pulses = 0, io_busy = 0.
  - Reset mid-frame discards the partial word with no flags.
- State changes and sampling occur only on clock edges where io_bit_en = 1, except output-handshake logic, which runs every cycle.
- IDLE: io_input = 1 -> DATA; counter = 0; shift register cleared. io_input = 0 -> stay in IDLE.
- DATA: on each strobe, capture io_input.
  - MSB_FIRST = 1: shift left, insert at bit 0.
  - MSB_FIRST = 0: shift right, insert at bit DATA_W-1.
  - Counter increments; after DATA_W bits go to PARITY if PARITY_EN, else STOP if STOP_EN, else frame end.
- PARITY: sample the parity bit. Error if XOR(payload, parity bit) = 1. Next state is STOP if STOP_EN, else frame end.
- STOP: sample the stop bit; error if it is 1. Always proceed to frame end.
- Frame end (same edge as the final bit sample):
  - State returns to IDLE. The next start bit is accepted on the next strobe.
  - If any error: pulse the relevant flag(s) for exactly one cycle (frame_err and parity_err may pulse together). Word is discarded; io_last_word is unchanged.
  - Good word: io_last_word <= word.
    - If the holding register is empty, or being consumed this cycle (valid && ready): io_out_data <= word and io_out_valid stays/becomes 1.
    - Otherwise the word is dropped, io_out_data is unchanged, and io_overrun pulses for one cycle.
- Latency: io_out_valid rises on the clock edge that samples the final bit of the frame, i.e. visible the cycle after that sample.
- Handshake:
  - valid && ready with no simultaneous new word -> io_out_valid <= 0 next cycle.
  - io_out_data is stable while valid && !ready.
- A stop bit sampled as 1 is not reinterpreted as a start bit.
- io_bit_en low for any number of cycles freezes all state; the handshake still operates.

Test Plan:
- Defaults, strobe every cycle, input 1,1,0,1,1,0,1,0,0,0 -> io_out_valid=1 with io_out_data=0xB4, one cycle after stop sample; io_last_word=0xB4.
- MSB_FIRST=0, same bit sequence -> io_out_data=0x2D.
- Strobe every 3rd cycle, frame for 0x5A -> 0x5A received; state is frozen between strobes (io_busy stays 1, no extra shifts).
- PARITY_EN=1, payload 0xB4 with parity bit 1 -> io_parity_err pulses 1 cycle, io_out_valid stays 0, io_last_word unchanged. With parity 0 -> 0xB4 delivered.
- Stop bit=1 -> io_frame_err 1-cycle pulse, no word, back to IDLE. A second frame (0x3C) immediately after is received correctly.
- io_out_ready=0; send 0x11 then 0x22 -> io_out_data remains 0x11, io_overrun pulses, io_last_word=0x22. With io_out_ready=1 in the 0x22 frame-end cycle, io_out_data=0x22 and there is no overrun. Assert reset mid-frame -> all outputs 0, next frame received cleanly.
